// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with a 2-bit saturating
// direction counter per entry. Looked up combinationally from the fetch PC,
// trained from the resolved conditional branch in EX. Table lives in flops
// so the IF lookup and the EX update can both happen in the same cycle.

// One table entry: valid bit, tag, target and direction counter.
module bp_entry #(
  parameter int TAG_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_tgt,
  input  logic [1:0]       wr_ctr,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output logic [31:0]      tgt,
  output logic [1:0]       ctr
);

  logic             valid_q, valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [1:0]       ctr_q, ctr_d;

  // Any write marks the entry valid; not-taken misses never reach here.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (we) begin
      valid_d = 1'b1;
      tag_d   = wr_tag;
      tgt_d   = wr_tgt;
      ctr_d   = wr_ctr;
    end
  end

  // Entry state; counters come out of reset weakly not-taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      tgt_q   <= '0;
      ctr_q   <= 2'b01;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
    end
  end

  assign valid = valid_q;
  assign tag   = tag_q;
  assign tgt   = tgt_q;
  assign ctr   = ctr_q;

endmodule

module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 32 - IDX_W - 2
) (
  input  logic        clk,
  input  logic        rst,
  // IF lookup
  input  logic [31:0] PCF,
  output logic        BTB_HitF,
  output logic        BHT_HitF,
  output logic [31:0] PredNPCF,
  // EX update
  input  logic        UpdateEn,
  input  logic        BranchE,
  input  logic        BrTakenE,
  input  logic [31:0] PCE,
  input  logic [31:0] BrTargetE,
  input  logic        BHT_HitE,
  output logic        MispredE,
  output logic [31:0] CorrectNPCE,
  // performance counters
  output logic [31:0] BranchCnt,
  output logic [31:0] MispredCnt
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0]            ent_valid;
  logic [ENTRIES-1:0][TAG_W-1:0] ent_tag;
  logic [ENTRIES-1:0][31:0]      ent_tgt;
  logic [ENTRIES-1:0][1:0]       ent_ctr;

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             upd;
  logic             hit_e;
  logic [1:0]       ctr_e;
  logic             wr_en;
  logic [31:0]      wr_tgt;
  logic [1:0]       wr_ctr;
  logic [ENTRIES-1:0] we_vec;

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // Low PC bits are always zero for aligned fetch; they play no part here.
  logic unused_pc_lo;
  assign unused_pc_lo = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[31:IDX_W+2];
  assign upd   = UpdateEn & BranchE;

  // Table storage: one entry instance per index.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    assign we_vec[i] = wr_en & (idx_e == IDX_W'(i));
    bp_entry #(.TAG_W(TAG_W)) u_ent (
      .clk    (clk),
      .rst    (rst),
      .we     (we_vec[i]),
      .wr_tag (tag_e),
      .wr_tgt (wr_tgt),
      .wr_ctr (wr_ctr),
      .valid  (ent_valid[i]),
      .tag    (ent_tag[i]),
      .tgt    (ent_tgt[i]),
      .ctr    (ent_ctr[i])
    );
  end

  // Fetch lookup reads the registered table, so a same-index update this
  // cycle is only seen from the next cycle on.
  always_comb begin
    BTB_HitF = ent_valid[idx_f] & (ent_tag[idx_f] == tag_f);
    BHT_HitF = BTB_HitF & ent_ctr[idx_f][1];
    PredNPCF = BHT_HitF ? ent_tgt[idx_f] : PCF + 32'd4;
  end

  // Training: hit is recomputed on the live table rather than trusting a
  // pipelined BTB hit, since the entry may have been replaced in between.
  always_comb begin
    hit_e  = ent_valid[idx_e] & (ent_tag[idx_e] == tag_e);
    ctr_e  = ent_ctr[idx_e];
    wr_en  = upd & (BrTakenE | hit_e);
    wr_tgt = BrTakenE ? BrTargetE : ent_tgt[idx_e];
    wr_ctr = ctr_e;
    if (BrTakenE) begin
      if (!hit_e)              wr_ctr = 2'b10;
      else if (ctr_e != 2'b11) wr_ctr = ctr_e + 2'd1;
    end else if (ctr_e != 2'b00) begin
      wr_ctr = ctr_e - 2'd1;
    end
  end

  // Misprediction redirect to the hazard unit.
  always_comb begin
    MispredE    = upd & (BHT_HitE != BrTakenE);
    CorrectNPCE = BrTakenE ? BrTargetE : PCE + 32'd4;
  end

  // Next values of the performance counters (wrap naturally).
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd)      branch_cnt_d  = branch_cnt_q + 32'd1;
    if (MispredE) mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign BranchCnt  = branch_cnt_q;
  assign MispredCnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus random traffic,
// checked by a scoreboard against an abstract table model.
module tb_branch_predictor;

  localparam int IDX_W = 6;
  localparam int N     = 1 << IDX_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PCF = '0;
  logic        BTB_HitF, BHT_HitF;
  logic [31:0] PredNPCF;
  logic        UpdateEn = 1'b0, BranchE = 1'b0, BrTakenE = 1'b0, BHT_HitE = 1'b0;
  logic [31:0] PCE = '0, BrTargetE = '0;
  logic        MispredE;
  logic [31:0] CorrectNPCE, BranchCnt, MispredCnt;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .PCF(PCF),
    .BTB_HitF(BTB_HitF), .BHT_HitF(BHT_HitF), .PredNPCF(PredNPCF),
    .UpdateEn(UpdateEn), .BranchE(BranchE), .BrTakenE(BrTakenE),
    .PCE(PCE), .BrTargetE(BrTargetE), .BHT_HitE(BHT_HitE),
    .MispredE(MispredE), .CorrectNPCE(CorrectNPCE),
    .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
  );

  // Reference model: one slot per index, holding the owning PC's upper
  // bits, the target and a 0..3 confidence value.
  bit          m_valid [N];
  logic [31:0] m_owner [N];
  logic [31:0] m_tgt   [N];
  int          m_conf  [N];
  logic [31:0] m_bcnt, m_mcnt;

  typedef struct {
    int          id;
    logic        btb, bht, misp;
    logic [31:0] npc, cnpc, bcnt, mcnt;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc_id = 0;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic logic [31:0] owner(input logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && m_owner[slot(pc)] == owner(pc);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && m_conf[slot(pc)] >= 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_owner[i] = '0; m_tgt[i] = '0; m_conf[i] = 1;
    end
    m_bcnt = '0; m_mcnt = '0;
  endtask

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  // One pipeline cycle: drive, predict the DUT response, let the edge
  // commit, then train the model the way the predictor should have.
  task automatic cyc(input bit r, input bit ue, input bit br, input bit tk,
                     input logic [31:0] pce, input logic [31:0] tgt,
                     input bit bhe, input logic [31:0] pcf);
    exp_t e;
    int   s;
    rst = r;
    if (r) model_reset();
    UpdateEn = ue; BranchE = br; BrTakenE = tk; PCE = pce;
    BrTargetE = tgt; BHT_HitE = bhe; PCF = pcf;
    e.id   = cyc_id;
    e.btb  = m_hit(pcf);
    e.bht  = m_pred(pcf);
    e.npc  = e.bht ? m_tgt[slot(pcf)] : pcf + 32'd4;
    e.misp = ue && br && (bhe != tk);
    e.cnpc = tk ? tgt : pce + 32'd4;
    e.bcnt = m_bcnt;
    e.mcnt = m_mcnt;
    sb.push_back(e);
    @(posedge clk);
    if (!r && ue && br) begin
      s = slot(pce);
      m_bcnt = m_bcnt + 1;
      if (bhe != tk) m_mcnt = m_mcnt + 1;
      if (tk) begin
        if (m_hit(pce)) m_conf[s] = (m_conf[s] < 3) ? m_conf[s] + 1 : 3;
        else begin
          m_valid[s] = 1; m_owner[s] = owner(pce); m_conf[s] = 2;
        end
        m_tgt[s] = tgt;
      end else if (m_hit(pce)) begin
        m_conf[s] = (m_conf[s] > 0) ? m_conf[s] - 1 : 0;
      end
    end
    cyc_id++;
    #1;
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("btb_hit_f",  e.id, 32'(BTB_HitF),  32'(e.btb));
      chk("bht_hit_f",  e.id, 32'(BHT_HitF),  32'(e.bht));
      chk("pred_npc_f", e.id, PredNPCF,       e.npc);
      chk("mispred_e",  e.id, 32'(MispredE),  32'(e.misp));
      if (e.misp) chk("correct_npc_e", e.id, CorrectNPCE, e.cnpc);
      chk("branch_cnt", e.id, BranchCnt,      e.bcnt);
      chk("mispred_cnt", e.id, MispredCnt,    e.mcnt);
    end
  end

  logic [31:0] pool [12] = '{32'h0000_0100, 32'h0000_1100, 32'h0000_0104, 32'h0000_0200,
                             32'h0000_2200, 32'h0000_03FC, 32'h0000_0000, 32'hFFFF_FFFC,
                             32'h0000_0040, 32'h0000_1040, 32'h8000_0100, 32'h0000_07F0};

  initial begin
    logic [31:0] pa, pf, tg;
    bit ue, br, tk, bhe;
    model_reset();
    @(posedge clk); #1;
    // reset held: lookup shows nothing and an update attempt is ignored
    cyc(1, 1, 1, 1, 32'h10, 32'h40, 0, 32'h10);
    cyc(1, 1, 1, 1, 32'h10, 32'h40, 0, 32'h10);
    cyc(0, 0, 0, 0, 32'h0,  32'h0,  0, 32'h10);
    // allocate on taken; same-cycle lookup sees the old (empty) entry
    cyc(0, 1, 1, 1, 32'h100, 32'h80, 0, 32'h100);
    cyc(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h100);
    // hysteresis: NT -> 01, T,T -> 11, T saturates, NT -> 10
    cyc(0, 1, 1, 0, 32'h100, 32'h80, m_pred(32'h100), 32'h100);
    cyc(0, 1, 1, 1, 32'h100, 32'h80, m_pred(32'h100), 32'h100);
    cyc(0, 1, 1, 1, 32'h100, 32'h84, m_pred(32'h100), 32'h100);
    cyc(0, 1, 1, 1, 32'h100, 32'h84, m_pred(32'h100), 32'h100);
    cyc(0, 1, 1, 0, 32'h100, 32'h84, m_pred(32'h100), 32'h100);
    cyc(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h100);
    // tag conflict replaces the entry; not-taken at unallocated PC is a no-op
    cyc(0, 1, 1, 1, 32'h1100, 32'h2000, m_pred(32'h1100), 32'h1100);
    cyc(0, 1, 1, 0, 32'h3000, 32'h0, 0, 32'h100);
    cyc(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h3000);
    cyc(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h1100);
    // hold: UpdateEn low freezes table and counters
    cyc(0, 0, 1, 1, 32'h500, 32'h600, 0, 32'h500);
    cyc(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h500);
    // PCF+4 wrap
    cyc(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'hFFFF_FFFC);
    // random traffic over aliasing PCs
    for (int k = 0; k < 400; k++) begin
      pa  = pool[$urandom_range(0, 11)];
      pf  = ($urandom_range(0, 3) == 0) ? pa : pool[$urandom_range(0, 11)];
      tg  = $urandom() & 32'hFFFF_FFFC;
      ue  = ($urandom_range(0, 7) != 0);
      br  = ($urandom_range(0, 4) != 0);
      tk  = $urandom_range(0, 1) == 1;
      bhe = ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) == 1) : m_pred(pa);
      cyc(0, ue, br, tk, pa, tg, bhe, pf);
    end
    // make sure something is valid, then reset asynchronously mid-cycle
    cyc(0, 1, 1, 1, 32'h240, 32'h999C, m_pred(32'h240), 32'h240);
    cyc(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h240);
    cyc(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h240);
    cyc(1, 1, 1, 1, 32'h240, 32'h1234, 0, 32'h240);
    cyc(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h240);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
